srio2udp_framer: RTL and testbench

Return-path framer from the SRIO target side toward the Ethernet/UDP transmit path: the reverse of the UDP-to-SRIO bridge. It accepts inbound NWRITE payload as a 64-bit beat stream, stores each packet whole, counts its bytes, then replays it as a 32-bit UDP payload stream. The byte length is presented from the first output beat onward. It runs entirely in the SRIO user clock domain; any crossing to the MAC clock is done downstream.

---
 rtl/srio2udp_framer_if.sv | 39 +++
 rtl/srio2udp_framer.sv | 204 ++++++++++++++++++++
 tb/tb_srio2udp_framer.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/srio2udp_framer_if.sv
// ============================================================================
//  Module   : srio2udp_framer_if
//  Purpose  : SRIO beat-in / UDP beat-out stream bundle for srio2udp_framer.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface srio2udp_framer_if;
    logic [63:0] srio_data_in;
    logic        srio_valid_in;
    logic        srio_first_in;
    logic [7:0]  srio_keep_in;
    logic        srio_last_in;
    logic        srio_ready_out;
    logic        udp_ready_in;
    logic [31:0] udp_data_out;
    logic        udp_valid_out;
    logic        udp_first_out;
    logic [3:0]  udp_keep_out;
    logic        udp_last_out;
    logic [15:0] udp_length_out;
    logic        err_oversize_out;

    modport master (
        output srio_data_in, srio_valid_in, srio_first_in, srio_keep_in, srio_last_in,
        output udp_ready_in,
        input  srio_ready_out, udp_data_out, udp_valid_out, udp_first_out,
        input  udp_keep_out, udp_last_out, udp_length_out, err_oversize_out
    );

    modport slave (
        input  srio_data_in, srio_valid_in, srio_first_in, srio_keep_in, srio_last_in,
        input  udp_ready_in,
        output srio_ready_out, udp_data_out, udp_valid_out, udp_first_out,
        output udp_keep_out, udp_last_out, udp_length_out, err_oversize_out
    );
endinterface

`default_nettype wire

// File: rtl/srio2udp_framer.sv
// ============================================================================
//  Module   : srio2udp_framer
//  Purpose  : Store-and-forward framer, 64-bit SRIO payload beats to 32-bit
//             UDP payload beats with byte length. Option: SRIO2UDP_BYTESWAP_EN.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module srio2udp_framer #(
    parameter int DATA_DEPTH = 128,
    parameter int LEN_DEPTH  = 4
) (
    input  wire logic          clk_srio,
    input  wire logic          reset_srio,
    srio2udp_framer_if.slave   bus
);
    localparam int             c_DAW       = $clog2(DATA_DEPTH);
    localparam int             c_LAW       = $clog2(LEN_DEPTH);
    localparam logic [5:0]     c_MAX_WORDS = 6'd32;
    localparam logic [c_DAW:0] c_DA_ONE    = 1;
    localparam logic [c_LAW:0] c_LQ_ONE    = 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HI   = 2'd1;
    localparam logic [1:0] S_LO   = 2'd2;

    // Buffer word = {payload[63:0], keep[7:0]}; queue entry = {bytes[15:0], words[5:0]}
    logic [71:0]    r_mem [DATA_DEPTH];
    logic [21:0]    r_lq  [LEN_DEPTH];
    logic [c_DAW:0] r_wr_ptr, r_rd_ptr;
    logic [c_LAW:0] r_lq_wr, r_lq_rd;
    logic [8:0]     r_byte_cnt;
    logic [5:0]     r_word_cnt;

    logic [1:0]     r_state, w_state_nx;
    logic [15:0]    r_len, w_len_nx;
    logic [5:0]     r_words, w_words_nx;
    logic           r_first, w_first_nx;

    logic           w_buf_full, w_lq_full, w_lq_empty, w_lq_more;
    logic           w_ready, w_accept, w_room, w_wr_en, w_push;
    logic [3:0]     w_pop;
    logic [8:0]     w_pkt_bytes;
    logic [21:0]    w_lq_entry, w_lq_head, w_lq_next;
    logic [c_LAW:0] w_lq_rd_inc;
    logic [7:0]     w_wr_keep;
    logic [71:0]    w_rd_word;
    logic           w_valid, w_last, w_first, w_rd_pop, w_lq_pop;
    logic [31:0]    w_half;
    logic [3:0]     w_keep4;
    logic           w_unused_first;

    assign w_unused_first = bus.srio_first_in;

    assign w_buf_full  = (r_wr_ptr[c_DAW] != r_rd_ptr[c_DAW]) &&
                         (r_wr_ptr[c_DAW-1:0] == r_rd_ptr[c_DAW-1:0]);
    assign w_lq_full   = (r_lq_wr[c_LAW] != r_lq_rd[c_LAW]) &&
                         (r_lq_wr[c_LAW-1:0] == r_lq_rd[c_LAW-1:0]);
    assign w_lq_empty  = (r_lq_wr == r_lq_rd);
    assign w_lq_rd_inc = r_lq_rd + c_LQ_ONE;
    assign w_lq_more   = (r_lq_wr != w_lq_rd_inc);

    assign w_ready  = !reset_srio && !w_buf_full && !w_lq_full;
    assign w_accept = bus.srio_valid_in && w_ready;
    // Only the first 32 beats of a packet are stored; later beats are swallowed
    assign w_room   = (r_word_cnt != c_MAX_WORDS);
    assign w_wr_en  = w_accept && w_room;
    assign w_push   = w_accept && bus.srio_last_in;

    always_comb begin
        w_pop = 4'd0;
        for (int i = 0; i < 8; i++) begin
            w_pop = w_pop + {3'd0, bus.srio_keep_in[i]};
        end
    end

    assign w_pkt_bytes = r_byte_cnt + {5'd0, w_pop};
    assign w_lq_entry  = w_room ? {7'd0, w_pkt_bytes, r_word_cnt + 6'd1}
                                : {16'd256, c_MAX_WORDS};
    assign w_wr_keep   = bus.srio_last_in ? bus.srio_keep_in : 8'hFF;

    always_ff @(posedge clk_srio) begin
        if (w_wr_en) r_mem[r_wr_ptr[c_DAW-1:0]] <= {bus.srio_data_in, w_wr_keep};
        if (w_push)  r_lq[r_lq_wr[c_LAW-1:0]]   <= w_lq_entry;
    end

    assign w_rd_word = r_mem[r_rd_ptr[c_DAW-1:0]];
    assign w_lq_head = r_lq[r_lq_rd[c_LAW-1:0]];
    assign w_lq_next = r_lq[w_lq_rd_inc[c_LAW-1:0]];

    always_ff @(posedge clk_srio) begin
        if (reset_srio) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_lq_wr    <= '0;
            r_lq_rd    <= '0;
            r_byte_cnt <= '0;
            r_word_cnt <= '0;
            r_state    <= S_IDLE;
            r_len      <= '0;
            r_words    <= '0;
            r_first    <= 1'b0;
        end else begin
            if (w_wr_en)  r_wr_ptr <= r_wr_ptr + c_DA_ONE;
            if (w_rd_pop) r_rd_ptr <= r_rd_ptr + c_DA_ONE;
            if (w_push)   r_lq_wr  <= r_lq_wr + c_LQ_ONE;
            if (w_lq_pop) r_lq_rd  <= w_lq_rd_inc;
            if (w_push) begin
                r_byte_cnt <= '0;
                r_word_cnt <= '0;
            end else if (w_wr_en) begin
                r_byte_cnt <= r_byte_cnt + 9'd8;
                r_word_cnt <= r_word_cnt + 6'd1;
            end
            r_state <= w_state_nx;
            r_len   <= w_len_nx;
            r_words <= w_words_nx;
            r_first <= w_first_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_len_nx   = r_len;
        w_words_nx = r_words;
        w_first_nx = r_first;
        w_valid    = 1'b0;
        w_last     = 1'b0;
        w_first    = 1'b0;
        w_half     = 32'd0;
        w_keep4    = 4'd0;
        w_rd_pop   = 1'b0;
        w_lq_pop   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_lq_empty) begin
                    w_state_nx = S_HI;
                    w_len_nx   = w_lq_head[21:6];
                    w_words_nx = w_lq_head[5:0];
                    w_first_nx = 1'b1;
                end
            end
            S_HI: begin
                w_valid = 1'b1;
                w_first = r_first;
                w_half  = w_rd_word[71:40];
                w_keep4 = w_rd_word[7:4];
                // MSB-contiguous keep: bit 3 clear means the final word fits in the upper half
                if (r_words == 6'd1 && !w_rd_word[3]) begin
                    w_last = 1'b1;
                    if (bus.udp_ready_in) begin
                        w_rd_pop   = 1'b1;
                        w_lq_pop   = 1'b1;
                        w_first_nx = 1'b0;
                        w_state_nx = S_IDLE;
                    end
                end else if (bus.udp_ready_in) begin
                    w_first_nx = 1'b0;
                    w_state_nx = S_LO;
                end
            end
            S_LO: begin
                w_valid = 1'b1;
                w_half  = w_rd_word[39:8];
                w_keep4 = w_rd_word[3:0];
                w_last  = (r_words == 6'd1);
                if (bus.udp_ready_in) begin
                    w_rd_pop = 1'b1;
                    if (w_last) begin
                        w_lq_pop = 1'b1;
                        if (w_lq_more) begin
                            w_state_nx = S_HI;
                            w_len_nx   = w_lq_next[21:6];
                            w_words_nx = w_lq_next[5:0];
                            w_first_nx = 1'b1;
                        end else begin
                            w_state_nx = S_IDLE;
                        end
                    end else begin
                        w_words_nx = r_words - 6'd1;
                        w_state_nx = S_HI;
                    end
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    assign bus.srio_ready_out   = w_ready;
    assign bus.err_oversize_out = w_push && !w_room;
    assign bus.udp_valid_out    = w_valid;
    assign bus.udp_first_out    = w_first;
    assign bus.udp_last_out     = w_last;
    assign bus.udp_length_out   = r_len;
`ifdef SRIO2UDP_BYTESWAP_EN
    assign bus.udp_data_out = {w_half[7:0], w_half[15:8], w_half[23:16], w_half[31:24]};
    assign bus.udp_keep_out = {w_keep4[0], w_keep4[1], w_keep4[2], w_keep4[3]};
`else
    assign bus.udp_data_out = w_half;
    assign bus.udp_keep_out = w_keep4;
`endif
endmodule

`default_nettype wire

// File: tb/tb_srio2udp_framer.sv
// ============================================================================
//  Module   : tb_srio2udp_framer
//  Purpose  : Scoreboard bench for srio2udp_framer (directed packets).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_srio2udp_framer;
    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        first;
        logic        last;
        logic [15:0] len;
    } beat_t;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    beat_t sb[$];
    beat_t cur, held, exp_b;
    logic  hold_v = 1'b0;
    int    n_vec = 0;
    int    n_err = 0;
    int    err_pulses = 0;
    logic  send_done;

    always #5 clk = ~clk;

    srio2udp_framer_if bus ();

    srio2udp_framer #(.DATA_DEPTH(128), .LEN_DEPTH(4)) dut (
        .clk_srio   (clk),
        .reset_srio (rst),
        .bus        (bus)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic push_exp(input logic [31:0] d, input logic [3:0] k,
                            input logic f, input logic l, input logic [15:0] len);
        beat_t b;
`ifdef SRIO2UDP_BYTESWAP_EN
        b.data = {d[7:0], d[15:8], d[23:16], d[31:24]};
        b.keep = {k[0], k[1], k[2], k[3]};
`else
        b.data = d;
        b.keep = k;
`endif
        b.first = f;
        b.last  = l;
        b.len   = len;
        sb.push_back(b);
    endtask

    // Reference split of a stored packet into 32-bit beats
    task automatic model_pkt(input int n, input logic [7:0] lastkeep,
                             input logic [63:0] w0, input logic [63:0] inc);
        int          nw;
        logic [7:0]  lk, k;
        logic [15:0] len;
        logic [63:0] w;
        logic        hl;
        nw  = (n > 32) ? 32 : n;
        lk  = (n > 32) ? 8'hFF : lastkeep;
        len = (n > 32) ? 16'd256 : 16'((n - 1) * 8 + $countones(lastkeep));
        for (int i = 0; i < nw; i++) begin
            w  = w0 + inc * 64'(i);
            k  = (i == nw - 1) ? lk : 8'hFF;
            hl = (i == nw - 1) && !k[3];
            push_exp(w[63:32], k[7:4], i == 0, hl, len);
            if (!hl) push_exp(w[31:0], k[3:0], 1'b0, i == nw - 1, len);
        end
    endtask

    task automatic send_beat(input logic [63:0] d, input logic [7:0] k,
                             input logic last, input logic first, input logic exp_err);
        int t;
        bus.srio_data_in  = d;
        bus.srio_keep_in  = k;
        bus.srio_last_in  = last;
        bus.srio_first_in = first;
        bus.srio_valid_in = 1'b1;
        t = 0;
        @(negedge clk);
        while (!bus.srio_ready_out && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!bus.srio_ready_out) begin
            n_vec++;
            n_err++;
            $display("FAIL srio_ready_timeout: got 0, expected 1 at %0t", $time);
        end else if (last) begin
            check("err_oversize", 64'(bus.err_oversize_out), 64'(exp_err));
        end
        @(posedge clk);
        #1;
        bus.srio_valid_in = 1'b0;
        bus.srio_last_in  = 1'b0;
        bus.srio_first_in = 1'b0;
    endtask

    task automatic send_pkt(input int n, input logic [7:0] lastkeep, input logic [63:0] w0,
                            input logic [63:0] inc, input logic gen_exp);
        if (gen_exp) model_pkt(n, lastkeep, w0, inc);
        for (int i = 0; i < n; i++) begin
            send_beat(w0 + inc * 64'(i), (i == n - 1) ? lastkeep : 8'hFF,
                      i == n - 1, i == 0, (i == n - 1) && (n > 32));
        end
    endtask

    task automatic wait_drain(input int budget);
        int t;
        t = 0;
        while ((sb.size() != 0 || bus.udp_valid_out) && t < budget) begin
            @(posedge clk);
            t++;
        end
        #1;
        check("drained", 64'(sb.size()), 64'd0);
    endtask

    task automatic check_all_zero(input string name);
        check(name, {bus.udp_data_out, bus.udp_keep_out, bus.udp_valid_out, bus.udp_first_out,
                     bus.udp_last_out, bus.udp_length_out, bus.srio_ready_out, bus.err_oversize_out},
              64'd0);
    endtask

    // Monitor: compare every handshaken beat, and hold-stability during stalls
    always @(negedge clk) begin
        cur = {bus.udp_data_out, bus.udp_keep_out, bus.udp_first_out,
               bus.udp_last_out, bus.udp_length_out};
        if (bus.err_oversize_out) err_pulses++;
        if (rst) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                check("stall_valid", 64'(bus.udp_valid_out), 64'd1);
                check("stall_hold", 64'(cur), 64'(held));
            end
            if (bus.udp_valid_out && bus.udp_ready_in) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_beat: got %0h, expected no beat at %0t", cur, $time);
                end else begin
                    exp_b = sb.pop_front();
                    check("beat", 64'(cur), 64'(exp_b));
                end
            end
            hold_v = bus.udp_valid_out && !bus.udp_ready_in;
            held   = cur;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.srio_data_in  = '0;
        bus.srio_keep_in  = '0;
        bus.srio_valid_in = 1'b0;
        bus.srio_first_in = 1'b0;
        bus.srio_last_in  = 1'b0;
        bus.udp_ready_in  = 1'b0;
        send_done         = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset_outputs");
        rst = 1'b0;
        #1;
        check("ready_after_reset", 64'(bus.srio_ready_out), 64'd1);
        bus.udp_ready_in = 1'b1;

        // Single 8-byte beat, with store-and-forward latency
        push_exp(32'h00112233, 4'hF, 1'b1, 1'b0, 16'd8);
        push_exp(32'h44556677, 4'hF, 1'b0, 1'b1, 16'd8);
        @(posedge clk);
        #1;
        send_pkt(1, 8'hFF, 64'h0011223344556677, 64'd0, 1'b0);
        check("latency_c1", 64'(bus.udp_valid_out), 64'd0);
        @(posedge clk);
        #1;
        check("latency_c2", 64'(bus.udp_valid_out), 64'd1);
        wait_drain(50);

        // 13-byte packet: tail lands in LO half
        push_exp(32'h01020304, 4'hF, 1'b1, 1'b0, 16'd13);
        push_exp(32'h05060708, 4'hF, 1'b0, 1'b0, 16'd13);
        push_exp(32'h11121314, 4'hF, 1'b0, 1'b0, 16'd13);
        push_exp(32'h15161718, 4'h8, 1'b0, 1'b1, 16'd13);
        send_pkt(2, 8'hF8, 64'h0102030405060708, 64'h1010101010101010, 1'b0);
        wait_drain(50);

        // 12-byte packet: ends on a HI beat
        push_exp(32'h01020304, 4'hF, 1'b1, 1'b0, 16'd12);
        push_exp(32'h05060708, 4'hF, 1'b0, 1'b0, 16'd12);
        push_exp(32'h11121314, 4'hF, 1'b0, 1'b1, 16'd12);
        send_pkt(2, 8'hF0, 64'h0102030405060708, 64'h1010101010101010, 1'b0);
        wait_drain(50);

        // 256-byte packet with toggling downstream ready
        send_done = 1'b0;
        fork
            begin
                send_pkt(32, 8'hFF, 64'hA0A1A2A3A4A5A6A7, 64'h0808080808080808, 1'b1);
                send_done = 1'b1;
            end
            begin
                for (int t = 0; t < 600; t++) begin
                    if (send_done && sb.size() == 0 && !bus.udp_valid_out) break;
                    @(posedge clk);
                    #1;
                    bus.udp_ready_in = ~bus.udp_ready_in;
                end
            end
        join
        bus.udp_ready_in = 1'b1;
        wait_drain(200);

        // Length queue fills at four packets while downstream is stalled
        bus.udp_ready_in = 1'b0;
        for (int p = 0; p < 4; p++) begin
            send_pkt(1, 8'hFF, 64'h1000000000000000 + 64'(p), 64'd0, 1'b1);
        end
        check("queue_full_ready", 64'(bus.srio_ready_out), 64'd0);
        @(posedge clk);
        #1;
        check("queue_full_hold", 64'(bus.srio_ready_out), 64'd0);
        bus.udp_ready_in = 1'b1;
        send_pkt(1, 8'hFF, 64'h1000000000000004, 64'd0, 1'b1);
        wait_drain(100);

        // Oversize: 40 beats in, 256 bytes out, one error pulse
        err_pulses = 0;
        send_pkt(40, 8'hFF, 64'hC0C1C2C3C4C5C6C7, 64'h0101010101010101, 1'b1);
        wait_drain(200);
        check("err_pulse_count", 64'(err_pulses), 64'd1);

        // Reset while a packet is streaming out
        send_pkt(8, 8'hFF, 64'h5500000000000000, 64'h0000000000000011, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        check("mid_output_valid", 64'(bus.udp_valid_out), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_all_zero("reset_mid_output");
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("ready_after_reset2", 64'(bus.srio_ready_out), 64'd1);
        repeat (20) @(posedge clk);
        #1;
        check("no_stale_beats", 64'(bus.udp_valid_out), 64'd0);

        push_exp(32'h00112233, 4'hF, 1'b1, 1'b0, 16'd8);
        push_exp(32'h44556677, 4'hF, 1'b0, 1'b1, 16'd8);
        send_pkt(1, 8'hFF, 64'h0011223344556677, 64'd0, 1'b0);
        wait_drain(50);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

`default_nettype wire
